keypad_event_scanner: RTL and testbench

Parametrised successor to the fixed 4x4 keypad scan and debounce front end: drives a ROWS x COLS matrix keypad, debounces every key independently, and emits press, release and typematic-repeat events through a small FIFO with a valid/ready handshake. It sits between the keypad pins and game/display logic. Consumers receive discrete key events instead of a level bitmap, so held keys and overlapping presses need no edge detection downstream.

---
 rtl/keypad_event_scanner.sv | 317 +++++++++++++++++++++++++++++++
 tb/tb_keypad_event_scanner.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_event_scanner.sv
// keypad_event_scanner
// Scans a ROWS x COLS matrix keypad one row at a time and debounces each key
// on its own. Press, release and typematic-repeat events go into a small FIFO
// that is read through a valid/ready handshake.
module keypad_event_scanner #(
   parameter int ROWS         = 4,
   parameter int COLS         = 4,
   parameter int DWELL_CYCLES = 50000,
   parameter int DEB_SCANS    = 10,
   parameter int REP_DELAY    = 50,
   parameter int REP_PERIOD   = 10,
   parameter int FIFO_DEPTH   = 8
) (
   input  logic                          clk,
   input  logic                          RSTn,
   input  logic [COLS-1:0]               col,
   output logic [ROWS-1:0]               row,
   input  logic                          repeat_en,
   output logic [ROWS*COLS-1:0]          key_state,
   output logic                          light,
   output logic                          ev_valid,
   input  logic                          ev_ready,
   output logic [1:0]                    ev_type,
   output logic [$clog2(ROWS*COLS)-1:0]  ev_code,
   output logic                          ovf,
   input  logic                          ovf_clr
);

   localparam int KEYS    = ROWS * COLS;
   localparam int CODE_W  = $clog2(KEYS);
   localparam int ROW_W   = $clog2(ROWS);
   localparam int COL_W   = $clog2(COLS);
   localparam int DWELL_W = $clog2(DWELL_CYCLES);
   // DRIVE is sized so that DRIVE + SAMPLE + COMMIT spans exactly DWELL_CYCLES,
   // which keeps the full scan period at ROWS*DWELL_CYCLES clocks.
   localparam int DRIVE_LEN = DWELL_CYCLES - COLS - 1;
   localparam int DEB_W   = $clog2(DEB_SCANS + 1);
   localparam int REP_MAX = (REP_DELAY > REP_PERIOD) ? REP_DELAY : REP_PERIOD;
   localparam int REP_W   = $clog2(REP_MAX + 1);
   localparam int ADDR_W  = $clog2(FIFO_DEPTH);
   localparam int ENT_W   = CODE_W + 2;

   localparam logic [1:0] EV_RELEASE = 2'b00;
   localparam logic [1:0] EV_PRESS   = 2'b01;
   localparam logic [1:0] EV_REPEAT  = 2'b10;

   typedef enum logic [1:0] {
      ST_DRIVE,
      ST_SAMPLE,
      ST_COMMIT
   } state_t;

   // ---------------------------------------------------------------------
   // Column synchroniser
   // ---------------------------------------------------------------------
   logic [COLS-1:0] col_meta_reg;
   logic [COLS-1:0] col_sync_reg;

   // Two-flop synchroniser; idle columns read high (pulled up).
   always_ff @(posedge clk or negedge RSTn) begin
      if (!RSTn) begin
         col_meta_reg <= '1;
         col_sync_reg <= '1;
      end else begin
         col_meta_reg <= col;
         col_sync_reg <= col_meta_reg;
      end
   end

   // ---------------------------------------------------------------------
   // Scan FSM
   // ---------------------------------------------------------------------
   state_t             state_reg, state_next;
   logic [DWELL_W-1:0] dwell_reg, dwell_next;
   logic [ROW_W-1:0]   row_idx_reg, row_idx_next;
   logic [COL_W-1:0]   col_idx_reg, col_idx_next;
   logic [COLS-1:0]    sample_reg, sample_next;

   // Scan state and counters register.
   always_ff @(posedge clk or negedge RSTn) begin
      if (!RSTn) begin
         state_reg   <= ST_DRIVE;
         dwell_reg   <= '0;
         row_idx_reg <= '0;
         col_idx_reg <= '0;
         sample_reg  <= '1;
      end else begin
         state_reg   <= state_next;
         dwell_reg   <= dwell_next;
         row_idx_reg <= row_idx_next;
         col_idx_reg <= col_idx_next;
         sample_reg  <= sample_next;
      end
   end

   // Next-state logic: settle the row, latch its columns, then walk the keys.
   always_comb begin
      state_next   = state_reg;
      dwell_next   = dwell_reg;
      row_idx_next = row_idx_reg;
      col_idx_next = col_idx_reg;
      sample_next  = sample_reg;
      case (state_reg)
         ST_DRIVE: begin
            if (dwell_reg == DWELL_W'(DRIVE_LEN - 1)) begin
               dwell_next = '0;
               state_next = ST_SAMPLE;
            end else begin
               dwell_next = dwell_reg + 1'b1;
            end
         end
         ST_SAMPLE: begin
            sample_next = col_sync_reg;
            state_next  = ST_COMMIT;
         end
         ST_COMMIT: begin
            if (col_idx_reg == COL_W'(COLS - 1)) begin
               col_idx_next = '0;
               state_next   = ST_DRIVE;
               row_idx_next = (row_idx_reg == ROW_W'(ROWS - 1)) ? '0 : row_idx_reg + 1'b1;
            end else begin
               col_idx_next = col_idx_reg + 1'b1;
            end
         end
         default: state_next = ST_DRIVE;
      endcase
   end

   assign row = ~(ROWS'(1) << row_idx_reg);

   logic              commit;
   logic [CODE_W-1:0] cur_key;
   logic              cur_raw;

   assign commit  = (state_reg == ST_COMMIT);
   assign cur_key = CODE_W'(row_idx_reg) * CODE_W'(COLS) + CODE_W'(col_idx_reg);
   assign cur_raw = ~sample_reg[col_idx_reg];

   // ---------------------------------------------------------------------
   // Per-key debounce
   // ---------------------------------------------------------------------
   logic [KEYS-1:0] press_vec;
   logic [KEYS-1:0] release_vec;

   genvar gi;
   generate
      for (gi = 0; gi < KEYS; gi++) begin : g_key
         localparam int KR = gi / COLS;
         localparam int KC = gi % COLS;
         logic             sel;
         logic             raw;
         logic             flip;
         logic             stable_reg, stable_next;
         logic [DEB_W-1:0] deb_cnt_reg, deb_cnt_next;

         assign sel = commit && (row_idx_reg == ROW_W'(KR)) && (col_idx_reg == COL_W'(KC));
         assign raw = ~sample_reg[KC];

         // Count consecutive disagreeing scans; flip the stable level once enough accumulate.
         always_comb begin
            deb_cnt_next = deb_cnt_reg;
            stable_next  = stable_reg;
            flip         = 1'b0;
            if (sel) begin
               if (raw == stable_reg) begin
                  deb_cnt_next = '0;
               end else if (deb_cnt_reg == DEB_W'(DEB_SCANS - 1)) begin
                  deb_cnt_next = '0;
                  stable_next  = ~stable_reg;
                  flip         = 1'b1;
               end else begin
                  deb_cnt_next = deb_cnt_reg + 1'b1;
               end
            end
         end

         // Debounce state register for this key.
         always_ff @(posedge clk or negedge RSTn) begin
            if (!RSTn) begin
               stable_reg  <= 1'b0;
               deb_cnt_reg <= '0;
            end else begin
               stable_reg  <= stable_next;
               deb_cnt_reg <= deb_cnt_next;
            end
         end

         assign key_state[gi]   = stable_reg;
         assign press_vec[gi]   = flip & ~stable_reg;
         assign release_vec[gi] = flip & stable_reg;
      end
   endgenerate

   logic press_any;
   logic release_any;

   assign press_any   = |press_vec;
   assign release_any = |release_vec;
   assign light       = |key_state;

   // ---------------------------------------------------------------------
   // Typematic repeat tracker (most recently pressed key only)
   // ---------------------------------------------------------------------
   logic              trk_armed_reg, trk_armed_next;
   logic              trk_first_reg, trk_first_next;
   logic [CODE_W-1:0] trk_code_reg, trk_code_next;
   logic [REP_W-1:0]  trk_cnt_reg, trk_cnt_next;
   logic [REP_W-1:0]  trk_cnt_inc;
   logic [REP_W-1:0]  trk_target;
   logic              rep_hit;

   assign trk_cnt_inc = trk_cnt_reg + 1'b1;
   assign trk_target  = trk_first_reg ? REP_W'(REP_DELAY) : REP_W'(REP_PERIOD);

   // Tracker state register.
   always_ff @(posedge clk or negedge RSTn) begin
      if (!RSTn) begin
         trk_armed_reg <= 1'b0;
         trk_first_reg <= 1'b1;
         trk_code_reg  <= '0;
         trk_cnt_reg   <= '0;
      end else begin
         trk_armed_reg <= trk_armed_next;
         trk_first_reg <= trk_first_next;
         trk_code_reg  <= trk_code_next;
         trk_cnt_reg   <= trk_cnt_next;
      end
   end

   // Retarget on press, disarm on release or disable, and count held scans.
   // Counting pauses while the raw pin reads released, so a key whose release
   // is still being debounced emits no further repeats.
   always_comb begin
      trk_armed_next = trk_armed_reg;
      trk_first_next = trk_first_reg;
      trk_code_next  = trk_code_reg;
      trk_cnt_next   = trk_cnt_reg;
      rep_hit        = 1'b0;
      if (press_any && repeat_en) begin
         trk_armed_next = 1'b1;
         trk_first_next = 1'b1;
         trk_code_next  = cur_key;
         trk_cnt_next   = '0;
      end else if (!repeat_en || (release_any && (cur_key == trk_code_reg))) begin
         trk_armed_next = 1'b0;
      end else if (trk_armed_reg && commit && (cur_key == trk_code_reg) && cur_raw) begin
         if (trk_cnt_inc == trk_target) begin
            rep_hit        = 1'b1;
            trk_cnt_next   = '0;
            trk_first_next = 1'b0;
         end else begin
            trk_cnt_next = trk_cnt_inc;
         end
      end
   end

   // ---------------------------------------------------------------------
   // Event FIFO
   // ---------------------------------------------------------------------
   logic             push_valid;
   logic [1:0]       push_type;
   logic             fifo_empty;
   logic             fifo_full;
   logic             pop;
   logic             push_ok;
   logic             drop;
   logic [ADDR_W:0]  wr_ptr_reg;
   logic [ADDR_W:0]  rd_ptr_reg;
   logic [ENT_W-1:0] mem_reg [FIFO_DEPTH];
   logic             ovf_reg;

   // A debounce flip on the committed key takes priority over a repeat.
   assign push_valid = press_any | release_any | rep_hit;
   assign push_type  = press_any ? EV_PRESS : (release_any ? EV_RELEASE : EV_REPEAT);

   assign fifo_empty = (wr_ptr_reg == rd_ptr_reg);
   assign fifo_full  = (wr_ptr_reg[ADDR_W] != rd_ptr_reg[ADDR_W]) &&
                       (wr_ptr_reg[ADDR_W-1:0] == rd_ptr_reg[ADDR_W-1:0]);
   assign pop        = ~fifo_empty & ev_ready;
   assign push_ok    = push_valid & (~fifo_full | pop);
   assign drop       = push_valid & ~push_ok;

   // FIFO storage and pointers; entries reset so the head reads zero after reset.
   always_ff @(posedge clk or negedge RSTn) begin
      if (!RSTn) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem_reg[i] <= '0;
         end
      end else begin
         if (push_ok) begin
            mem_reg[wr_ptr_reg[ADDR_W-1:0]] <= {push_type, cur_key};
            wr_ptr_reg <= wr_ptr_reg + 1'b1;
         end
         if (pop) begin
            rd_ptr_reg <= rd_ptr_reg + 1'b1;
         end
      end
   end

   // Sticky overflow flag; a new drop outranks a clear in the same cycle.
   always_ff @(posedge clk or negedge RSTn) begin
      if (!RSTn) begin
         ovf_reg <= 1'b0;
      end else if (drop) begin
         ovf_reg <= 1'b1;
      end else if (ovf_clr) begin
         ovf_reg <= 1'b0;
      end
   end

   assign ovf                = ovf_reg;
   assign ev_valid           = ~fifo_empty;
   assign {ev_type, ev_code} = mem_reg[rd_ptr_reg[ADDR_W-1:0]];

endmodule

// File: tb/tb_keypad_event_scanner.sv
// Self-checking bench for keypad_event_scanner: a behavioural keypad drives the
// columns, expected events are queued as stimulus is applied and compared as
// the DUT hands them out.
module tb_keypad_event_scanner;

   localparam int ROWS  = 4;
   localparam int COLS  = 4;
   localparam int DWELL = 16;
   localparam int DEB   = 10;
   localparam int RDLY  = 5;
   localparam int RPER  = 2;
   localparam int DEPTH = 4;
   localparam int KEYS  = ROWS * COLS;
   localparam int SCAN  = ROWS * DWELL;

   localparam logic [1:0] T_REL = 2'b00;
   localparam logic [1:0] T_PRS = 2'b01;
   localparam logic [1:0] T_REP = 2'b10;

   logic            clk;
   logic            RSTn;
   logic [COLS-1:0] col;
   logic [ROWS-1:0] row;
   logic            repeat_en;
   logic [KEYS-1:0] key_state;
   logic            light;
   logic            ev_valid;
   logic            ev_ready;
   logic [1:0]      ev_type;
   logic [3:0]      ev_code;
   logic            ovf;
   logic            ovf_clr;

   logic [KEYS-1:0] pressed;

   keypad_event_scanner #(
      .ROWS(ROWS), .COLS(COLS), .DWELL_CYCLES(DWELL), .DEB_SCANS(DEB),
      .REP_DELAY(RDLY), .REP_PERIOD(RPER), .FIFO_DEPTH(DEPTH)
   ) dut (
      .clk(clk), .RSTn(RSTn), .col(col), .row(row), .repeat_en(repeat_en),
      .key_state(key_state), .light(light), .ev_valid(ev_valid),
      .ev_ready(ev_ready), .ev_type(ev_type), .ev_code(ev_code),
      .ovf(ovf), .ovf_clr(ovf_clr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Keypad matrix: a pressed key pulls its column low while its row is driven low.
   always_comb begin
      col = '1;
      for (int r = 0; r < ROWS; r++) begin
         for (int c = 0; c < COLS; c++) begin
            if (pressed[r*COLS+c] && !row[r]) col[c] = 1'b0;
         end
      end
   end

   typedef struct {
      logic [1:0] typ;
      int         code;
      int         lo;
      int         hi;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   int   n_checks = 0;
   int   n_errors = 0;
   int   scan_cnt = 0;
   logic [ROWS-1:0] row_prev = '1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, req);
      end
   endtask

   task automatic push_exp(input logic [1:0] t, input int code, input int lo, input int hi);
      exp_t e;
      e.typ = t; e.code = code; e.lo = lo; e.hi = hi;
      exp_q.push_back(e);
   endtask

   // Scan counter (row wrap) and scoreboard monitor, both away from the rising edge.
   always @(negedge clk) begin
      if (RSTn && !row_prev[ROWS-1] && !row[0]) scan_cnt++;
      row_prev = row;
      if (RSTn && ev_valid && ev_ready) begin
         $display("event type=%0d code=%0d scan=%0d", ev_type, ev_code, scan_cnt);
         if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_event: got type=%0d code=%0d, required none", ev_type, ev_code);
         end else begin
            mon_e = exp_q.pop_front();
            check("ev_type", 32'(ev_type), 32'(mon_e.typ));
            check("ev_code", 32'(ev_code), 32'(mon_e.code));
            n_checks++;
            if (scan_cnt < mon_e.lo || scan_cnt > mon_e.hi) begin
               n_errors++;
               $display("FAIL ev_scan: got %0d required %0d..%0d", scan_cnt, mon_e.lo, mon_e.hi);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic wait_scan_until(input int target);
      int budget;
      budget = (target - scan_cnt + 2) * SCAN + 50;
      while (scan_cnt < target && budget > 0) begin
         tick();
         budget--;
      end
      if (scan_cnt < target) begin
         n_checks++;
         n_errors++;
         $display("FAIL scan_timeout: got scan %0d required %0d", scan_cnt, target);
      end
   endtask

   typedef struct {
      int code;
      int hold;
      bit exp_press;
   } vec_t;

   vec_t vecs[5];

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish, required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int s, r, last, p;
      vecs[0] = '{9, 12, 1'b1};
      vecs[1] = '{0, 10, 1'b1};
      vecs[2] = '{15, 11, 1'b1};
      vecs[3] = '{6, 9, 1'b0};
      vecs[4] = '{12, 10, 1'b1};

      pressed = '0; repeat_en = 1'b0; ev_ready = 1'b1; ovf_clr = 1'b0; RSTn = 1'b0;
      repeat (3) tick();
      check("rst_row", 32'(row), 32'(4'b1110));
      check("rst_key_state", 32'(key_state), 32'd0);
      check("rst_light", 32'(light), 32'd0);
      check("rst_ev_valid", 32'(ev_valid), 32'd0);
      check("rst_ev_type", 32'(ev_type), 32'd0);
      check("rst_ev_code", 32'(ev_code), 32'd0);
      check("rst_ovf", 32'(ovf), 32'd0);
      RSTn = 1'b1;

      // Table of single-key holds; hold below DEB_SCANS must stay silent.
      for (int i = 0; i < 5; i++) begin
         wait_scan_until(scan_cnt + 1);
         s = scan_cnt;
         last = (vecs[i].code == KEYS - 1) ? 1 : 0;
         pressed[vecs[i].code] = 1'b1;
         if (vecs[i].exp_press) push_exp(T_PRS, vecs[i].code, s + DEB - 1 + last, s + DEB - 1 + last);
         wait_scan_until(s + vecs[i].hold);
         check("vec_key_state_held", 32'(key_state), vecs[i].exp_press ? (32'd1 << vecs[i].code) : 32'd0);
         check("vec_light_held", 32'(light), 32'(vecs[i].exp_press));
         pressed[vecs[i].code] = 1'b0;
         r = scan_cnt;
         if (vecs[i].exp_press) push_exp(T_REL, vecs[i].code, r + DEB - 1 + last, r + DEB - 1 + last);
         wait_scan_until(r + DEB + 2);
         check("vec_key_state_idle", 32'(key_state), 32'd0);
         check("vec_light_idle", 32'(light), 32'd0);
         check("vec_queue_empty", 32'(exp_q.size()), 32'd0);
      end

      // Bounce on key 0 for 8 scans, then a steady hold.
      wait_scan_until(scan_cnt + 1);
      s = scan_cnt;
      for (int i = 0; i < 8; i++) begin
         pressed[0] = (i % 2 == 0);
         wait_scan_until(s + i + 1);
      end
      pressed[0] = 1'b1;
      push_exp(T_PRS, 0, s + 8 + DEB - 1, s + 8 + DEB - 1);
      wait_scan_until(s + 8 + DEB + 2);
      pressed[0] = 1'b0;
      r = scan_cnt;
      push_exp(T_REL, 0, r + DEB - 1, r + DEB - 1);
      wait_scan_until(r + DEB + 2);
      check("bounce_queue_empty", 32'(exp_q.size()), 32'd0);

      // Keys 0 and 15 pressed in the same scan.
      wait_scan_until(scan_cnt + 1);
      s = scan_cnt;
      pressed[0] = 1'b1; pressed[15] = 1'b1;
      push_exp(T_PRS, 0, s + DEB - 1, s + DEB - 1);
      push_exp(T_PRS, 15, s + DEB, s + DEB);
      wait_scan_until(s + 12);
      check("dual_key_state", 32'(key_state), 32'h8001);
      pressed[0] = 1'b0; pressed[15] = 1'b0;
      r = scan_cnt;
      push_exp(T_REL, 0, r + DEB - 1, r + DEB - 1);
      push_exp(T_REL, 15, r + DEB, r + DEB);
      wait_scan_until(r + DEB + 2);
      check("dual_queue_empty", 32'(exp_q.size()), 32'd0);

      // Overflow: six events into a four-entry FIFO with the consumer stalled.
      ev_ready = 1'b0;
      wait_scan_until(scan_cnt + 1);
      s = scan_cnt;
      pressed[1] = 1'b1; pressed[2] = 1'b1; pressed[3] = 1'b1;
      push_exp(T_PRS, 1, s, s + 60);
      push_exp(T_PRS, 2, s, s + 60);
      push_exp(T_PRS, 3, s, s + 60);
      wait_scan_until(s + 12);
      pressed[1] = 1'b0; pressed[2] = 1'b0; pressed[3] = 1'b0;
      push_exp(T_REL, 1, s, s + 60);
      wait_scan_until(s + 12 + DEB + 1);
      check("ovf_set", 32'(ovf), 32'd1);
      check("ovf_head_valid", 32'(ev_valid), 32'd1);
      check("ovf_head_type", 32'(ev_type), 32'(T_PRS));
      check("ovf_head_code", 32'(ev_code), 32'd1);
      ovf_clr = 1'b1;
      tick();
      ovf_clr = 1'b0;
      tick();
      check("ovf_cleared", 32'(ovf), 32'd0);
      ev_ready = 1'b1;
      repeat (10) tick();
      check("ovf_queue_drained", 32'(exp_q.size()), 32'd0);
      check("ovf_valid_drained", 32'(ev_valid), 32'd0);

      // Typematic repeat on key 5.
      repeat_en = 1'b1;
      wait_scan_until(scan_cnt + 1);
      s = scan_cnt;
      p = s + DEB - 1;
      pressed[5] = 1'b1;
      push_exp(T_PRS, 5, p, p);
      for (int k = 0; k < 5; k++) push_exp(T_REP, 5, p + RDLY + k * RPER, p + RDLY + k * RPER);
      wait_scan_until(p + 15);
      pressed[5] = 1'b0;
      push_exp(T_REL, 5, p + 15 + DEB - 1, p + 15 + DEB - 1);
      wait_scan_until(p + 15 + DEB + 4);
      check("repeat_queue_empty", 32'(exp_q.size()), 32'd0);
      repeat_en = 1'b0;

      // Reset in the middle of COMMIT with key 3 held and its event queued.
      ev_ready = 1'b0;
      wait_scan_until(scan_cnt + 1);
      s = scan_cnt;
      pressed[3] = 1'b1;
      wait_scan_until(s + DEB + 1);
      check("pre_rst_valid", 32'(ev_valid), 32'd1);
      check("pre_rst_code", 32'(ev_code), 32'd3);
      check("pre_rst_key_state", 32'(key_state), 32'h0008);
      wait_scan_until(scan_cnt + 1);
      repeat (12) tick();
      RSTn = 1'b0;
      #1;
      check("mid_rst_row", 32'(row), 32'(4'b1110));
      check("mid_rst_key_state", 32'(key_state), 32'd0);
      check("mid_rst_light", 32'(light), 32'd0);
      check("mid_rst_ev_valid", 32'(ev_valid), 32'd0);
      check("mid_rst_ev_type", 32'(ev_type), 32'd0);
      check("mid_rst_ev_code", 32'(ev_code), 32'd0);
      check("mid_rst_ovf", 32'(ovf), 32'd0);
      repeat (3) tick();
      RSTn = 1'b1;
      ev_ready = 1'b1;
      s = scan_cnt;
      push_exp(T_PRS, 3, s, s + DEB + 2);
      wait_scan_until(s + DEB + 3);
      check("post_rst_key_state", 32'(key_state), 32'h0008);
      check("post_rst_queue_empty", 32'(exp_q.size()), 32'd0);
      pressed[3] = 1'b0;
      r = scan_cnt;
      push_exp(T_REL, 3, r + DEB - 1, r + DEB - 1);
      wait_scan_until(r + DEB + 3);
      check("final_queue_empty", 32'(exp_q.size()), 32'd0);
      check("final_key_state", 32'(key_state), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
